// File: rtl/sys_issue_seq.sv
// -----------------------------------------------------------------------------
// sys_issue_seq
//
// Serialising issue sequencer placed directly in front of the system
// functional unit (sys_unit). It takes one decoded system op from issue,
// waits until the rest of the pipeline has drained, fires sys_unit for a
// single cycle, captures its one-cycle-latency result, and hands the result
// to writeback over a valid/ready handshake. Issue stays stalled from the
// moment the op is accepted until the sequencer returns to idle.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid / o_ready     op handshake from issue
//   i_op, i_src1, i_src2  decoded system op and its operands
//   i_rd                  destination register index
//   i_pipe_empty          no other instruction in flight
//   i_flush               pipeline flush, abandons the held op
//   o_stall               hold the issue stage
//   o_sys_enabled         one-cycle fire strobe to sys_unit
//   o_sys_op/src1/src2    latched op and operands to sys_unit
//   i_sys_dest            sys_unit result, valid the cycle after the fire
//   o_wb_valid / i_wb_ready  writeback handshake
//   o_wb_rd, o_wb_data    writeback register index and data
//   o_timeout             drain has lasted DRAIN_TIMEOUT cycles (level)
// -----------------------------------------------------------------------------

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef DECODED_ALU_OP_T_DEFINED
`define DECODED_ALU_OP_T_DEFINED
typedef enum logic [3:0] {
    ALU_NOP    = 4'd0,
    ALU_CSRRW  = 4'd1,
    ALU_CSRRS  = 4'd2,
    ALU_CSRRC  = 4'd3,
    ALU_ECALL  = 4'd4,
    ALU_EBREAK = 4'd5,
    ALU_MRET   = 4'd6,
    ALU_WFI    = 4'd7,
    ALU_FENCE  = 4'd8
} decoded_alu_op_t;
`endif

// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | no op held, ready to accept from issue
// S_DRAIN  | op held, waiting for the rest of the pipeline to empty
// S_ISSUE  | o_sys_enabled high for this single cycle
// S_CAPTURE| sys_unit result present on i_sys_dest, latched at end of cycle
// S_WB     | result offered to writeback until i_wb_ready
module sys_issue_seq #(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int REG_IDX_WIDTH = 5,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,

    input  logic                     i_valid,
    output logic                     o_ready,
    input  decoded_alu_op_t          i_op,
    input  logic [DATA_WIDTH-1:0]    i_src1,
    input  logic [DATA_WIDTH-1:0]    i_src2,
    input  logic [REG_IDX_WIDTH-1:0] i_rd,

    input  logic                     i_pipe_empty,
    input  logic                     i_flush,
    output logic                     o_stall,

    output logic                     o_sys_enabled,
    output decoded_alu_op_t          o_sys_op,
    output logic [DATA_WIDTH-1:0]    o_sys_src1,
    output logic [DATA_WIDTH-1:0]    o_sys_src2,
    input  logic [DATA_WIDTH-1:0]    i_sys_dest,

    output logic                     o_wb_valid,
    input  logic                     i_wb_ready,
    output logic [REG_IDX_WIDTH-1:0] o_wb_rd,
    output logic [DATA_WIDTH-1:0]    o_wb_data,

    output logic                     o_timeout
);

    // A zero timeout would make $clog2 yield a zero-width counter.
    localparam int CNT_WIDTH = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DRAIN_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t                   state;

    decoded_alu_op_t          op_q;
    logic [DATA_WIDTH-1:0]    src1_q;
    logic [DATA_WIDTH-1:0]    src2_q;
    logic [REG_IDX_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [CNT_WIDTH-1:0]     drain_cnt;

    // Output flags are registered copies of the state decode, updated in the
    // same branch that moves the state so they can never disagree with it.
    logic                     ready_q;
    logic                     sys_en_q;
    logic                     wb_valid_q;
    logic                     timeout_q;

    logic [CNT_WIDTH-1:0]     drain_cnt_inc;

    assign drain_cnt_inc = drain_cnt + CNT_ONE;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            op_q       <= ALU_NOP;
            src1_q     <= '0;
            src2_q     <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            drain_cnt  <= '0;
            ready_q    <= 1'b1;
            sys_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (i_flush) begin
            // Held operands stay in place; only the sequence is abandoned,
            // so a result still in flight from sys_unit is simply dropped.
            state      <= S_IDLE;
            ready_q    <= 1'b1;
            sys_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        op_q      <= i_op;
                        src1_q    <= i_src1;
                        src2_q    <= i_src2;
                        rd_q      <= i_rd;
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                        ready_q   <= 1'b0;
                        timeout_q <= (CNT_MAX == '0);
                    end
                end

                S_DRAIN: begin
                    if (i_pipe_empty) begin
                        state     <= S_ISSUE;
                        sys_en_q  <= 1'b1;
                        timeout_q <= 1'b0;
                    end else if (drain_cnt != CNT_MAX) begin
                        // Saturate at the limit; once there, timeout_q is
                        // already high and simply stays so while we wait.
                        drain_cnt <= drain_cnt_inc;
                        timeout_q <= (drain_cnt_inc == CNT_MAX);
                    end
                end

                S_ISSUE: begin
                    state    <= S_CAPTURE;
                    sys_en_q <= 1'b0;
                end

                S_CAPTURE: begin
                    result_q <= i_sys_dest;
                    // x0 is never written, so skip the writeback handshake.
                    if (rd_q == '0) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state      <= S_WB;
                        wb_valid_q <= 1'b1;
                    end
                end

                S_WB: begin
                    if (i_wb_ready) begin
                        state      <= S_IDLE;
                        wb_valid_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    ready_q    <= 1'b1;
                    sys_en_q   <= 1'b0;
                    wb_valid_q <= 1'b0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = ready_q;
    // Stall is asserted in the accept cycle itself so issue does not advance
    // past the op being handed over.
    assign o_stall       = ~ready_q | i_valid;

    assign o_sys_enabled = sys_en_q;
    assign o_sys_op      = op_q;
    assign o_sys_src1    = src1_q;
    assign o_sys_src2    = src2_q;

    assign o_wb_valid    = wb_valid_q;
    assign o_wb_rd       = rd_q;
    assign o_wb_data     = result_q;

    assign o_timeout     = timeout_q;

endmodule
